// File: rtl/cplx_pkg.sv
// rtl/cplx_pkg.sv - shared types, mode bit positions and width helper for cplx_mac
package cplx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REAL = 2'd1,
    ST_IMAG = 2'd2,
    ST_OUT  = 2'd3
  } state_e;

  localparam int MODE_CONJ = 0;
  localparam int MODE_ACC  = 1;

  // Two full-scale products plus log2(frame) growth bits never overflow.
  function automatic int out_width(input int w, input int acc_n);
    return 2 * w + 1 + $clog2(acc_n);
  endfunction

endpackage

// File: rtl/cplx_mul_core.sv
// rtl/cplx_mul_core.sv - two shared multipliers producing the real or imaginary partial sum
module cplx_mul_core #(
  parameter int W = 8
) (
  input  logic signed [W-1:0] ar_i,
  input  logic signed [W-1:0] ai_i,
  input  logic signed [W-1:0] br_i,
  input  logic signed [W-1:0] bi_i,
  input  logic                sel_imag_i,
  input  logic                conj_i,
  output logic signed [2*W:0] sum_o
);

  logic signed [W-1:0]   x0, x1;
  logic signed [2*W-1:0] p0, p1;
  logic signed [2*W:0]   e0, e1;
  logic                  sub;

  // Real pass pairs (a_r,b_r)/(a_i,b_i); imag pass swaps the A operands.
  assign x0 = sel_imag_i ? ai_i : ar_i;
  assign x1 = sel_imag_i ? ar_i : ai_i;
  assign p0 = x0 * br_i;
  assign p1 = x1 * bi_i;

  assign e0 = {p0[2*W-1], p0};
  assign e1 = {p1[2*W-1], p1};

  // Normal real and conjugate imag subtract; the other two add.
  assign sub   = (sel_imag_i == conj_i);
  assign sum_o = sub ? (e0 - e1) : (e0 + e1);

endmodule

// File: rtl/cplx_mac.sv
// rtl/cplx_mac.sv - complex multiply / frame accumulate with valid/ready handshakes
module cplx_mac
  import cplx_pkg::*;
#(
  parameter  int W     = 8,
  parameter  int ACC_N = 4,
  localparam int OW    = out_width(W, ACC_N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [W-1:0]  a_r,
  input  logic signed [W-1:0]  a_i,
  input  logic signed [W-1:0]  b_r,
  input  logic signed [W-1:0]  b_i,
  input  logic [1:0]           mode,
  input  logic                 i_valid,
  output logic                 i_ready,
  output logic signed [OW-1:0] o_r,
  output logic signed [OW-1:0] o_i,
  output logic                 o_valid,
  input  logic                 o_ready
);

  localparam int CW = (ACC_N > 1) ? $clog2(ACC_N) : 1;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic signed [W-1:0]   ar_q, ar_d, ai_q, ai_d, br_q, br_d, bi_q, bi_d;
  logic [1:0]            mode_q, mode_d;
  logic signed [OW-1:0]  acc_r_q, acc_r_d, acc_i_q, acc_i_d;
  logic signed [2*W:0]   core_sum;
  logic signed [OW-1:0]  term;
  logic                  acc_hold;
  logic                  frame_last;

  cplx_mul_core #(.W(W)) u_core (
    .ar_i       (ar_q),
    .ai_i       (ai_q),
    .br_i       (br_q),
    .bi_i       (bi_q),
    .sel_imag_i (state_q == ST_IMAG),
    .conj_i     (mode_q[MODE_CONJ]),
    .sum_o      (core_sum)
  );

  assign term       = OW'(core_sum);
  assign acc_hold   = mode_q[MODE_ACC] && (cnt_q != '0);
  assign frame_last = !mode_q[MODE_ACC] || (cnt_q == CW'(ACC_N - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ar_d    = ar_q;
    ai_d    = ai_q;
    br_d    = br_q;
    bi_d    = bi_q;
    mode_d  = mode_q;
    acc_r_d = acc_r_q;
    acc_i_d = acc_i_q;
    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          ar_d    = a_r;
          ai_d    = a_i;
          br_d    = b_r;
          bi_d    = b_i;
          // Mode is latched per frame so later samples cannot change it.
          if (cnt_q == '0) mode_d = mode;
          state_d = ST_REAL;
        end
      end
      ST_REAL: begin
        acc_r_d = acc_hold ? (acc_r_q + term) : term;
        state_d = ST_IMAG;
      end
      ST_IMAG: begin
        acc_i_d = acc_hold ? (acc_i_q + term) : term;
        if (frame_last) begin
          state_d = ST_OUT;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = ST_IDLE;
        end
      end
      ST_OUT: begin
        if (o_ready) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ar_q    <= '0;
      ai_q    <= '0;
      br_q    <= '0;
      bi_q    <= '0;
      mode_q  <= '0;
      acc_r_q <= '0;
      acc_i_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ar_q    <= ar_d;
      ai_q    <= ai_d;
      br_q    <= br_d;
      bi_q    <= bi_d;
      mode_q  <= mode_d;
      acc_r_q <= acc_r_d;
      acc_i_q <= acc_i_d;
    end
  end

  assign i_ready = (state_q == ST_IDLE);
  assign o_valid = (state_q == ST_OUT);
  assign o_r     = acc_r_q;
  assign o_i     = acc_i_q;

endmodule

// File: doc/cplx_mac.md
# cplx_mac

Parametrised complex multiply / multiply-accumulate unit with valid/ready handshakes. It is the next generation of the team's two-cycle complex multiplier. It keeps the two shared real multipliers, time-multiplexed over a REAL and an IMAG cycle. It adds three things: generic operand width, a conjugate-B mode, and accumulation over a frame of `ACC_N` samples with output back-pressure. It sits between sample sources (FFT twiddle, correlator taps) and downstream filtering.

## Interface
- `W`, 8: signed operand width (≥2).
- `ACC_N`, 4: samples per accumulation frame (≥1).
- Derived localparam `OW = 2*W + 1 + $clog2(ACC_N)`: output width.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-low reset.
- `a_r`, `a_i`  in  W: signed operand A (real, imaginary).
- `b_r`, `b_i`  in  W: signed operand B.
- `mode`  in  2: bit0 = conjugate B; bit1 = accumulate.
- `i_valid`  in  1: operands and mode valid.
- `i_ready`  out  1: block can accept a sample.
- `o_r`, `o_i`  out  OW: signed result.
- `o_valid`  out  1: result valid.
- `o_ready`  in  1: downstream accepts the result.

## Operation
- States: IDLE, REAL, IMAG, OUT.
- IDLE
  - `i_ready`=1.
  - On `i_valid`, register a_*, b_*, mode → REAL.
  - `mode` is captured only on the first sample of a frame (cnt==0). Later samples of the frame reuse the captured mode.
- REAL
  - Normal: real = a_r*b_r − a_i*b_i.
  - Conj: real = a_r*b_r + a_i*b_i.
  - If cnt==0 or not accumulating: acc_r ← real. Otherwise acc_r ← acc_r + real.
  - → IMAG.
- IMAG
  - Normal: imag = a_r*b_i + a_i*b_r.
  - Conj: imag = a_i*b_r − a_r*b_i.
  - acc_i is updated the same way as acc_r.
  - If not accumulating, or cnt==ACC_N−1: → OUT.
  - Otherwise cnt++ → IDLE.
- OUT
  - `o_valid`=1; `o_r`/`o_i` = acc_r/acc_i, held stable.
  - On `o_ready`: cnt←0 → IDLE.
- Arithmetic
  - Each product is sign-extended to OW before add/sub.
  - OW is sized so a full frame of worst-case products (−2^(W−1) squared, two terms) never overflows. No saturation, no rounding.
- Reset (rst==0 at a clock edge)
  - state=IDLE, cnt=0, acc_r=acc_i=0, o_r=o_i=0, o_valid=0.
  - `i_ready`=1 from the first cycle after reset.
  - A reset mid-frame or mid-OUT discards all partial state.
- With ACC_N==1, accumulate mode behaves exactly like multiply mode.
- `i_valid` outside IDLE is ignored and does not stall any state.
- `o_ready` outside OUT is ignored.

## Timing
- Sample accepted at edge k. REAL computes during cycle k+1 and IMAG during cycle k+2.
- `o_valid` is high from the cycle after edge k+3 (3-cycle latency) when multiply, or when accumulating and this is the last frame sample.
- Maximum throughput, multiply mode with `o_ready` tied high: one sample per 4 cycles (IDLE, REAL, IMAG, OUT).
- Non-final frame samples take 3 cycles each (no OUT).
- `i_ready` is combinational from state only (IDLE). `o_valid` is combinational from state only (OUT). Neither depends on the other handshake input.
- `o_r`/`o_i` are registered. Their values change only on a REAL/IMAG update or reset.

## Structure
- Package `cplx_pkg` holds:
  - state enum (IDLE, REAL, IMAG, OUT);
  - mode bit-position constants (`MODE_CONJ`=0, `MODE_ACC`=1);
  - function `out_width(W, ACC_N)`.
- Sub-module `cplx_mul_core #(W)` is purely combinational:
  - inputs: operands, `sel_imag`, `conj`;
  - output: one signed 2W+1 partial sum;
  - contains the two multipliers and the operand-swap muxes.
- The top level holds the FSM, frame counter, accumulators and handshakes.

## Test plan
- W=8, mode=00, (3+4j)·(5+6j), `o_ready`=1 → `o_valid` 3 cycles after accept, o_r=−9, o_i=38, then `i_ready` back to 1.
- mode=01, same operands → o_r=39, o_i=2. Then (−128−128j)·(−128−128j) with mode=00 → o_r=0, o_i=32768; with mode=01 → o_r=32768, o_i=0.
- ACC_N=4, mode=10, four samples of (3+4j)·(5+6j) → a single `o_valid` after the 4th sample, o_r=−36, o_i=152. `mode` changed to 00 on samples 2–4 has no effect.
- Back-pressure: hold `o_ready`=0 for 5 cycles in OUT → o_r/o_i/`o_valid` stable and `i_ready`=0 throughout. Release → IDLE next cycle.
- Reset: assert rst=0 during IMAG of the 2nd frame sample → o_r=o_i=0, `o_valid`=0. The next 4-sample frame yields exactly −36/152 with no residue.
- ACC_N=1, mode=10 → result identical to mode=00 for random operands, compared against a reference model over 1000 samples.
